// File: rtl/weight_stream_ctrl_if.sv
// Beat stream from weight_stream_ctrl to the PE array: one word pair per transfer.
// Signals: out_valid/out_ready handshake, out_data_a (word base+2k), out_data_b (word base+2k+1),
//          out_b_valid (out_data_b is a real word), out_last (final beat of the run).
// Modports: master = weight fetch engine, slave = PE side (owns out_ready).
interface weight_stream_ctrl_if #(
  parameter int WORD_W = 72
);
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data_a;
  logic [WORD_W-1:0] out_data_b;
  logic              out_b_valid;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data_a,
    output out_data_b,
    output out_b_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data_a,
    input  out_data_b,
    input  out_b_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/weight_stream_ctrl.sv
// Weight fetch engine: streams a programmed run of ROM words, two per cycle, to the PE array.
// Latency: start sampled at edge 0 -> first ROM address in cycle 1 -> first out_valid in cycle ROM_LAT+2.
// Backpressure: credit-limited; a read is issued only when FIFO occupancy + reads in flight < FIFO_DEPTH.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start/base_addr/num_words  run request, sampled only in IDLE
//   busy, done                 run in progress, one-cycle end-of-run pulse
//   rom_addr_a/b, rom_dout_a/b dual-port ROM (even words on A, odd words on B)
//   out_bus                    valid/ready beat stream to the PEs (master side)
module weight_stream_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int WORD_W     = 72,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      num_words,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    rom_addr_a,
  output logic [ADDR_W-1:0]    rom_addr_b,
  input  logic [WORD_W-1:0]    rom_dout_a,
  input  logic [WORD_W-1:0]    rom_dout_b,
  weight_stream_ctrl_if.master out_bus
);

  localparam int BW = ADDR_W + 1;                // beat / word counter width
  localparam int CW = $clog2(FIFO_DEPTH + 1);    // credit counter width, must hold FIFO_DEPTH
  localparam int PW = $clog2(FIFO_DEPTH);        // FIFO index width
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  // Tag travelling alongside each issued read until its ROM data appears.
  typedef struct packed {
    logic vld;
    logic b_vld;
    logic last;
  } tag_t;

  // One FIFO entry: the word pair plus its framing bits.
  typedef struct packed {
    logic [WORD_W-1:0] dat_a;
    logic [WORD_W-1:0] dat_b;
    logic              b_vld;
    logic              last;
  } beat_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic              load;

  logic [ADDR_W-1:0] addr_nxt_q;     // port A address of the next beat to issue
  logic [BW-1:0]     beats_left_q;   // beats still to issue in this run
  logic              odd_q;          // run has an odd word count
  logic [CW-1:0]     used_q;         // FIFO occupancy + reads in flight

  tag_t              iss_tag_q;      // tag aligned with the registered ROM address
  tag_t              pipe_q [ROM_LAT];

  // Zero-length run: done two edges after start, matching the normal start-to-action delay.
  logic              zero_pend_q;
  logic              zero_done_q;

  // Output FIFO
  beat_t             mem_q [FIFO_DEPTH];
  logic [PW:0]       wr_ptr_q, rd_ptr_q;
  logic              fifo_empty;
  beat_t             head;
  beat_t             push_beat;
  logic              push;

  logic              pop;
  logic              issue;
  logic              last_beat;
  logic              drain_done;
  logic [BW-1:0]     beats_init;

  // ---------------------------------------------------------------------------
  // Control terms
  // ---------------------------------------------------------------------------
  assign pop        = out_bus.out_valid & out_bus.out_ready;
  assign last_beat  = (beats_left_q == BW'(1));
  // A slot freed by a same-cycle handshake may be reused by this issue.
  assign issue      = (state_q == FETCH) && ((used_q < DEPTH_C) || pop);
  // used_q == 0 means nothing in flight and the FIFO is empty, so out_valid is already low.
  assign drain_done = (state_q == DRAIN) && (used_q == '0);
  assign beats_init = (num_words >> 1) + BW'(num_words[0]);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (num_words != '0)) begin
          state_d = FETCH;
          load    = 1'b1;
        end
      end
      FETCH: begin
        if (issue && last_beat) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE) && !drain_done;
  assign done = zero_done_q | drain_done;

  // ---------------------------------------------------------------------------
  // Address generation and run bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_nxt_q   <= '0;
      beats_left_q <= '0;
      odd_q        <= 1'b0;
      rom_addr_a   <= '0;
      rom_addr_b   <= '0;
      zero_pend_q  <= 1'b0;
      zero_done_q  <= 1'b0;
    end else begin
      zero_pend_q <= (state_q == IDLE) && start && (num_words == '0);
      zero_done_q <= zero_pend_q;
      if (load) begin
        addr_nxt_q   <= base_addr;
        beats_left_q <= beats_init;
        odd_q        <= num_words[0];
      end else if (issue) begin
        // Addresses wrap modulo 2^ADDR_W through natural overflow.
        rom_addr_a   <= addr_nxt_q;
        rom_addr_b   <= addr_nxt_q + ADDR_W'(1);
        addr_nxt_q   <= addr_nxt_q + ADDR_W'(2);
        beats_left_q <= beats_left_q - BW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline: iss_tag_q sits with the address register, pipe_q then
  // delays it ROM_LAT cycles so the last stage lines up with rom_dout.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_tag_q <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      iss_tag_q.vld   <= issue;
      iss_tag_q.b_vld <= !(last_beat && odd_q);
      iss_tag_q.last  <= last_beat;
      pipe_q[0]       <= iss_tag_q;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used_q <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   used_q <= used_q + CW'(1);
        2'b01:   used_q <= used_q - CW'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. Credit guarantees push never hits a full FIFO. Entries are
  // not reset; clearing the pointers empties it.
  // ---------------------------------------------------------------------------
  assign push            = pipe_q[ROM_LAT-1].vld;
  assign push_beat.dat_a = rom_dout_a;
  assign push_beat.dat_b = rom_dout_b;
  assign push_beat.b_vld = pipe_q[ROM_LAT-1].b_vld;
  assign push_beat.last  = pipe_q[ROM_LAT-1].last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= push_beat;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = mem_q[rd_ptr_q[PW-1:0]];

  // Head entry only moves on a pop, so the beat is stable while stalled.
  assign out_bus.out_valid   = !fifo_empty;
  assign out_bus.out_data_a  = head.dat_a;
  assign out_bus.out_data_b  = head.dat_b;
  assign out_bus.out_b_valid = !fifo_empty && head.b_vld;
  assign out_bus.out_last    = !fifo_empty && head.last;

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Directed bench for weight_stream_ctrl: two instances (ROM_LAT=1/DEPTH=4 and ROM_LAT=3/DEPTH=8)
// with behavioural ROMs; cycle k is the interval after clock edge k, start is sampled at edge 0.
// Inputs change on the falling edge, outputs are sampled there too.
module tb_weight_stream_ctrl;
  localparam int AW = 14;
  localparam int WW = 72;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 1: ROM_LAT=1, FIFO_DEPTH=4
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   nw;
  logic          busy, done;
  logic [AW-1:0] addr_a, addr_b;
  logic [WW-1:0] dout_a, dout_b;
  weight_stream_ctrl_if #(.WORD_W(WW)) ob ();

  // Instance 2: ROM_LAT=3, FIFO_DEPTH=8
  logic          start2;
  logic [AW-1:0] base2;
  logic [AW:0]   nw2;
  logic          busy2, done2;
  logic [AW-1:0] addr2_a, addr2_b;
  logic [WW-1:0] dout2_a, dout2_b;
  weight_stream_ctrl_if #(.WORD_W(WW)) ob2 ();

  weight_stream_ctrl #(.ADDR_W(AW), .WORD_W(WW), .ROM_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .num_words(nw),
    .busy(busy), .done(done), .rom_addr_a(addr_a), .rom_addr_b(addr_b),
    .rom_dout_a(dout_a), .rom_dout_b(dout_b), .out_bus(ob)
  );

  weight_stream_ctrl #(.ADDR_W(AW), .WORD_W(WW), .ROM_LAT(3), .FIFO_DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .base_addr(base2), .num_words(nw2),
    .busy(busy2), .done(done2), .rom_addr_a(addr2_a), .rom_addr_b(addr2_b),
    .rom_dout_a(dout2_a), .rom_dout_b(dout2_b), .out_bus(ob2)
  );

  // ROM image: distinct, address-derived content for every word.
  function automatic logic [WW-1:0] rom_f(input logic [AW-1:0] a);
    return {a, 8'hC3, 36'(a) * 36'd12345, ~a};
  endfunction

  logic [WW-1:0] r1_a, r1_b;
  always @(posedge clk) begin
    r1_a <= rom_f(addr_a);
    r1_b <= rom_f(addr_b);
  end
  assign dout_a = r1_a;
  assign dout_b = r1_b;

  logic [WW-1:0] r2_a [3];
  logic [WW-1:0] r2_b [3];
  always @(posedge clk) begin
    r2_a[0] <= rom_f(addr2_a);
    r2_b[0] <= rom_f(addr2_b);
    r2_a[1] <= r2_a[0];
    r2_b[1] <= r2_b[0];
    r2_a[2] <= r2_a[1];
    r2_b[2] <= r2_b[1];
  end
  assign dout2_a = r2_a[2];
  assign dout2_b = r2_b[2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_addr(input string tag, input logic [AW-1:0] a);
    logic [AW-1:0] b;
    b = a + 14'd1;
    chk({tag, "_aa"}, addr_a, a);
    chk({tag, "_ab"}, addr_b, b);
  endtask

  task automatic chk_beat(input string tag, input logic [AW-1:0] a, input logic bv, input logic last);
    logic [AW-1:0] b;
    b = a + 14'd1;
    chk({tag, "_vld"}, ob.out_valid, 1'b1);
    chk({tag, "_da"}, ob.out_data_a, rom_f(a));
    if (bv) chk({tag, "_db"}, ob.out_data_b, rom_f(b));
    chk({tag, "_bv"}, ob.out_b_valid, bv);
    chk({tag, "_last"}, ob.out_last, last);
  endtask

  int hs, done_cyc, last_cyc;

  initial begin
    rst = 1'b1;
    start = 1'b0; base = '0; nw = '0;
    start2 = 1'b0; base2 = '0; nw2 = '0;
    ob.out_ready = 1'b1;
    ob2.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_vld", ob.out_valid, 1'b0);
    chk("rst_bv", ob.out_b_valid, 1'b0);
    chk("rst_last", ob.out_last, 1'b0);
    chk("rst_aa", addr_a, 14'h0);
    chk("rst_ab", addr_b, 14'h0);
    chk("rst_vld2", ob2.out_valid, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // 1: even run, base 0x10, 6 words
    base = 14'h0010; nw = 15'd6; start = 1'b1;
    tick(); start = 1'b0;                       // cycle 0
    chk("t1_busy_c0", busy, 1'b1);
    chk("t1_vld_c0", ob.out_valid, 1'b0);
    tick(); chk_addr("t1_c1", 14'h0010); chk("t1_vld_c1", ob.out_valid, 1'b0);
    tick(); chk_addr("t1_c2", 14'h0012); chk("t1_vld_c2", ob.out_valid, 1'b0);
    tick(); chk_addr("t1_c3", 14'h0014); chk_beat("t1_b0", 14'h0010, 1'b1, 1'b0);
    tick(); chk_beat("t1_b1", 14'h0012, 1'b1, 1'b0);
    tick(); chk_beat("t1_b2", 14'h0014, 1'b1, 1'b1); chk("t1_done_c5", done, 1'b0);
    tick(); chk("t1_done_c6", done, 1'b1); chk("t1_busy_c6", busy, 1'b0); chk("t1_vld_c6", ob.out_valid, 1'b0);
    tick(); chk("t1_done_c7", done, 1'b0);

    // 2: odd run with address wrap
    base = 14'h3FFE; nw = 15'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_addr("t2_c1", 14'h3FFE);
    tick(); chk_addr("t2_c2", 14'h0000);
    tick(); chk_addr("t2_c3", 14'h0002); chk_beat("t2_b0", 14'h3FFE, 1'b1, 1'b0);
    tick(); chk_beat("t2_b1", 14'h0000, 1'b1, 1'b0);
    tick(); chk_beat("t2_b2", 14'h0002, 1'b0, 1'b1);
    tick(); chk("t2_done_c6", done, 1'b1);
    tick();

    // 3: 16 words with out_ready low in cycles 3-12
    base = 14'h0040; nw = 15'd16; start = 1'b1;
    tick(); start = 1'b0;
    hs = 0; done_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 80 && done_cyc < 0; cyc++) begin
      ob.out_ready = !(cyc >= 3 && cyc <= 12);
      if (cyc == 3) chk("t3_hold_c3", ob.out_data_a, rom_f(14'h0040));
      if (cyc == 12) begin
        chk("t3_credit_aa", addr_a, 14'h0046);
        chk("t3_vld_c12", ob.out_valid, 1'b1);
        chk("t3_hold_c12", ob.out_data_a, rom_f(14'h0040));
      end
      if (done) begin
        done_cyc = cyc;
        chk("t3_done_vld", ob.out_valid, 1'b0);
      end else if (ob.out_valid && ob.out_ready) begin
        chk($sformatf("t3_b%0d_da", hs), ob.out_data_a, rom_f(AW'(64 + 2 * hs)));
        chk($sformatf("t3_b%0d_db", hs), ob.out_data_b, rom_f(AW'(65 + 2 * hs)));
        chk($sformatf("t3_b%0d_last", hs), ob.out_last, (hs == 7));
        if (ob.out_last) last_cyc = cyc;
        hs++;
      end
      if (done_cyc < 0) tick();
    end
    chk("t3_beats", hs, 8);
    chk("t3_done_after_last", done_cyc, last_cyc + 1);
    tick();
    chk("t3_done_once", done, 1'b0);
    ob.out_ready = 1'b1;

    // 4: zero-length run
    base = 14'h0123; nw = 15'd0; start = 1'b1;
    tick(); start = 1'b0;
    chk("t4_done_c0", done, 1'b0); chk("t4_busy_c0", busy, 1'b0);
    tick();
    chk("t4_done_c1", done, 1'b1); chk("t4_busy_c1", busy, 1'b0);
    chk("t4_no_issue", addr_a, 14'h004E);
    tick();
    chk("t4_done_c2", done, 1'b0);

    // 5: reset mid-run with FIFO non-empty
    ob.out_ready = 1'b0;
    base = 14'h0080; nw = 15'd16; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick(); tick();                     // cycle 3
    chk("t5_vld_pre", ob.out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_vld", ob.out_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_aa", addr_a, 14'h0);
    chk("t5_rst_last", ob.out_last, 1'b0);
    tick(); tick();
    rst = 1'b0;
    ob.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_quiet%0d", i), ob.out_valid, 1'b0);
    end
    base = 14'h0100; nw = 15'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); chk_addr("t5_c1", 14'h0100);
    tick(); chk_addr("t5_c2", 14'h0102);
    tick(); chk_beat("t5_b0", 14'h0100, 1'b1, 1'b0);
    tick(); chk_beat("t5_b1", 14'h0102, 1'b0, 1'b1);
    tick(); chk("t5_done", done, 1'b1);
    tick();

    // 6: ROM_LAT=3, 32 words back to back, stray start mid-run
    base2 = 14'h0200; nw2 = 15'd32; start2 = 1'b1;
    tick(); start2 = 1'b0;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick();
      if (cyc == 7) begin start2 = 1'b1; base2 = 14'h1000; nw2 = 15'd4; end
      if (cyc == 8) start2 = 1'b0;
      if (cyc == 4) chk("t6_vld_c4", ob2.out_valid, 1'b0);
      if (cyc >= 5 && cyc <= 20) begin
        chk($sformatf("t6_vld_c%0d", cyc), ob2.out_valid, 1'b1);
        chk($sformatf("t6_da_c%0d", cyc), ob2.out_data_a, rom_f(AW'(512 + 2 * (cyc - 5))));
        chk($sformatf("t6_db_c%0d", cyc), ob2.out_data_b, rom_f(AW'(513 + 2 * (cyc - 5))));
        chk($sformatf("t6_last_c%0d", cyc), ob2.out_last, (cyc == 20));
      end
      if (cyc == 21) begin
        chk("t6_done_c21", done2, 1'b1);
        chk("t6_vld_c21", ob2.out_valid, 1'b0);
      end
      if (cyc == 22) begin
        chk("t6_done_c22", done2, 1'b0);
        chk("t6_busy_c22", busy2, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/weight_stream_ctrl.md
Name: weight_stream_ctrl

Overview:
- Parametrised weight-fetch engine that sits between the dual-port weight ROM and the PE array.
- Replaces hand-wired ROM address logic with one block that streams a programmed run of packed-kernel words. The default is 72-bit, i.e. a 3x3 kernel of 8-bit weights.
- Reads two words per cycle, one per ROM port, and tolerates a configurable ROM read latency.
- Delivers word pairs to the PEs through a valid/ready interface with a credit-limited output FIFO.

Parameters:
- ADDR_W, 14, ROM address width; num_words is ADDR_W+1 bits.
- WORD_W, 72, ROM word width (9 weights x 8 bits).
- ROM_LAT, 1, ROM read latency in cycles from address to dout; legal 1..3.
- FIFO_DEPTH, 4, output FIFO depth in beats (pairs); must be >= ROM_LAT+2 for full throughput; power of two.

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first ROM word address; sampled with start
- num_words  in  ADDR_W+1  number of words to fetch (0..2^ADDR_W); sampled with start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- rom_addr_a  out  ADDR_W  ROM port A address (even words of the run)
- rom_addr_b  out  ADDR_W  ROM port B address (odd words of the run)
- rom_dout_a  in  WORD_W  ROM port A data, valid ROM_LAT cycles after address
- rom_dout_b  in  WORD_W  ROM port B data
- out_valid  out  1  beat available
- out_ready  in  1  PE side accepts beat
- out_data_a  out  WORD_W  word base+2k
- out_data_b  out  WORD_W  word base+2k+1
- out_b_valid  out  1  out_data_b holds a real word
- out_last  out  1  final beat of run

Behaviour:
- Reset (async, any state): FSM to IDLE.
  - busy, done, out_valid, out_b_valid and out_last are 0.
  - rom_addr_a and rom_addr_b are 0.
  - FIFO is emptied and the in-flight valid pipeline cleared; ROM data returning after reset is discarded.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: when start=1, latch base_addr and num_words.
    - num_words=0: stay IDLE and pulse done next cycle; busy stays 0.
    - Otherwise go to FETCH with busy=1.
  - FETCH: issue one beat per cycle when credit allows.
    - On beat k: rom_addr_a = base+2k and rom_addr_b = base+2k+1, both mod 2^ADDR_W (addresses wrap).
    - After issuing beat ceil(num_words/2)-1, go to DRAIN.
  - DRAIN: wait until all in-flight reads have landed and the FIFO has emptied through out handshakes.
    - Then pulse done for one cycle and return to IDLE; busy drops in the same cycle done pulses.
- start while busy: ignored, no error.
- Credit rule: issue only if FIFO occupancy + reads in flight < FIFO_DEPTH, so the FIFO never overflows.
  - An issue in the same cycle as an out handshake may use the freed slot.
- Read pipeline: a ROM_LAT-deep shift register of {valid, b_valid, last} tags accompanies each issued beat.
  - The tagged ROM data is pushed into the FIFO when its tag emerges.
- Odd num_words: the final beat has out_b_valid=0.
  - out_data_b is driven with whatever port B returned; consumers ignore it.
  - rom_addr_b is still driven (wrapped) on that beat.
- Output timing: the FIFO is registered.
  - Start sampled at edge 0 gives first address in cycle 1, first out_valid in cycle ROM_LAT+2.
  - With out_ready held high, one beat per cycle thereafter.
- Handshake: a beat transfers when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_data_a, out_data_b, out_b_valid and out_last are held stable.
- done: asserted the cycle after the handshake of the out_last beat.
  - Never asserted while out_valid=1.
- FIFO full and empty are handled internally; out_valid = FIFO not empty.

Test Plan:
1. Reset, then start with base=0x0010, num_words=6, out_ready=1 (ROM_LAT=1) -> addr pairs (0x10,0x11), (0x12,0x13), (0x14,0x15) in cycles 1-3; out_valid in cycles 3-5 with matching data; out_last on the 3rd beat; done in cycle 6.
2. num_words=5, base=0x3FFE -> addr pairs (0x3FFE,0x3FFF), (0x0000,0x0001), (0x0002,0x0003); 3rd beat has out_b_valid=0 and out_last=1; data matches ROM image at the wrapped addresses.
3. num_words=16 with out_ready low for cycles 3-12 -> no more than FIFO_DEPTH beats in FIFO plus flight; output held stable; all 8 beats delivered in order with no loss or duplication; done after the last handshake.
4. num_words=0 -> no ROM issue, busy stays 0, done pulses once in cycle 1.
5. Assert rst mid-run (after beat 2 issued, FIFO non-empty) -> outputs drop to reset values immediately; late ROM data is not presented; a new start after release runs cleanly.
6. ROM_LAT=3, FIFO_DEPTH=8, num_words=32, out_ready=1 -> first out_valid in cycle 5; 16 back-to-back beats; start pulse asserted mid-run is ignored.
